empaquetador_simbolos: RTL and testbench

Downstream consumer of the 2-bit memory-mux output. It accepts a stream of DATA_W-bit symbols under a valid/ready handshake and packs N_SYM consecutive symbols, MSB-first, into one output word. The word is held in a registered output stage with its own valid/ready handshake. It also keeps a running count of delivered words, giving the mux datapath a byte-wide, flow-controlled interface toward later stages.

---
 rtl/empaquetador_simbolos_pkg.sv | 12 +
 rtl/empaquetador_simbolos_contador_palabras.sv | 21 ++
 rtl/empaquetador_simbolos.sv | 89 ++++++++
 tb/tb_empaquetador_simbolos.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/empaquetador_simbolos_pkg.sv
// Shared definitions for the symbol packer: default widths and FSM state encoding.
package empaquetador_simbolos_pkg;

  localparam int DATA_W_DEF = 2;
  localparam int N_SYM_DEF  = 4;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/empaquetador_simbolos_contador_palabras.sv
// 8-bit wrapping word counter: increments on en_i, result registered; no backpressure.
module contador_palabras (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  output logic [7:0] count_o
);

  logic [7:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'd0;
    end else if (en_i) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/empaquetador_simbolos.sv
// Packs N_SYM symbols MSB-first into one word; word valid one edge after last symbol.
// Two-word stall capacity (output stage + accumulator); ready_out drops only in HOLD.
module empaquetador_simbolos
  import empaquetador_simbolos_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_SYM  = N_SYM_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic [DATA_W*N_SYM-1:0] data_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic [7:0]              word_count
);

  localparam int OUT_W = DATA_W * N_SYM;
  localparam int CNT_W = $clog2(N_SYM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SYM - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [OUT_W-1:0]   acc_q;
  logic [OUT_W-1:0]   data_q;
  logic               valid_q;

  logic               out_free;
  logic               out_hs;
  logic [OUT_W-1:0]   acc_shift;

  assign out_free  = !valid_q || ready_in;
  assign out_hs    = valid_q && ready_in;
  assign acc_shift = {acc_q[OUT_W-DATA_W-1:0], data_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      // A delivered word clears valid unless a new word is loaded below.
      if (out_hs) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        ST_FILL: begin
          if (valid_in) begin
            if (cnt_q != CNT_LAST) begin
              acc_q <= acc_shift;
              cnt_q <= cnt_q + 1'b1;
            end else if (out_free) begin
              data_q  <= acc_shift;
              valid_q <= 1'b1;
              cnt_q   <= '0;
            end else begin
              acc_q   <= acc_shift;
              state_q <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (out_free) begin
            data_q  <= acc_q;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_FILL;
          end
        end
      endcase
    end
  end

  assign ready_out = (state_q == ST_FILL);
  assign data_out  = data_q;
  assign valid_out = valid_q;

  contador_palabras u_contador (
    .clk     (clk),
    .rst     (reset),
    .en_i    (out_hs),
    .count_o (word_count)
  );

endmodule

// File: tb/tb_empaquetador_simbolos.sv
// Directed bench for empaquetador_simbolos with hand-computed expected words.
module tb_empaquetador_simbolos;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] data_in = 2'b00;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic [7:0] data_out;
  logic       valid_out;
  logic       ready_in = 1'b0;
  logic [7:0] word_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  empaquetador_simbolos dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .word_count (word_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s);
    data_in  = s;
    valid_in = 1'b1;
    step();
  endtask

  int gaps;
  int bad_words;

  initial begin
    // Reset values while reset held
    #2;
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'h00);
    chk("rst_wc", 32'(word_count), 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("rst_ready", 32'(ready_out), 32'd1);

    // Single word 11,01,10,00 -> D8
    ready_in = 1'b1;
    send(2'b11);
    chk("t1_novalid_early", 32'(valid_out), 32'd0);
    send(2'b01);
    send(2'b10);
    send(2'b00);
    chk("t1_valid", 32'(valid_out), 32'd1);
    chk("t1_data", 32'(data_out), 32'hD8);
    chk("t1_wc_before", 32'(word_count), 32'd0);
    valid_in = 1'b0;
    step();
    chk("t1_wc_after", 32'(word_count), 32'd1);
    chk("t1_valid_clear", 32'(valid_out), 32'd0);
    chk("t1_data_kept", 32'(data_out), 32'hD8);

    // Stall: two words with ready_in low
    ready_in = 1'b0;
    send(2'b11); send(2'b11); send(2'b11); send(2'b11);
    chk("t2_valid_ff", 32'(valid_out), 32'd1);
    chk("t2_data_ff", 32'(data_out), 32'hFF);
    chk("t2_ready_fill", 32'(ready_out), 32'd1);
    send(2'b00); send(2'b00); send(2'b00); send(2'b01);
    chk("t2_hold_ready", 32'(ready_out), 32'd0);
    chk("t2_hold_data", 32'(data_out), 32'hFF);
    chk("t2_hold_valid", 32'(valid_out), 32'd1);
    // Producer keeps offering while stalled; must be ignored
    data_in = 2'b10;
    step();
    chk("t2_stall_ready", 32'(ready_out), 32'd0);
    chk("t2_stall_data", 32'(data_out), 32'hFF);
    valid_in = 1'b0;
    ready_in = 1'b1;
    step();
    chk("t2_reload_data", 32'(data_out), 32'h01);
    chk("t2_reload_valid", 32'(valid_out), 32'd1);
    chk("t2_reload_ready", 32'(ready_out), 32'd1);
    chk("t2_wc", 32'(word_count), 32'd2);
    step();
    chk("t2_wc_final", 32'(word_count), 32'd3);
    chk("t2_valid_clear", 32'(valid_out), 32'd0);

    // Fresh reset, then 1024 symbols back-to-back: word_count wraps to 0
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    gaps = 0;
    bad_words = 0;
    for (int i = 0; i < 1024; i++) begin
      if (ready_out !== 1'b1) gaps++;
      send(2'(i % 4));
      if ((i % 4) == 3 && (valid_out !== 1'b1 || data_out !== 8'h1B)) bad_words++;
    end
    chk("t3_ready_gaps", 32'(gaps), 32'd0);
    chk("t3_bad_words", 32'(bad_words), 32'd0);
    chk("t3_wc_255", 32'(word_count), 32'd255);
    valid_in = 1'b0;
    step();
    chk("t3_wc_wrap", 32'(word_count), 32'd0);

    // Reset asserted mid-word takes effect immediately
    send(2'b11);
    send(2'b10);
    valid_in = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("t4_rst_valid", 32'(valid_out), 32'd0);
    chk("t4_rst_data", 32'(data_out), 32'h00);
    chk("t4_rst_ready", 32'(ready_out), 32'd1);
    step();
    reset = 1'b0;
    step();
    send(2'b01); send(2'b01); send(2'b01); send(2'b01);
    chk("t4_data", 32'(data_out), 32'h55);
    chk("t4_valid", 32'(valid_out), 32'd1);
    valid_in = 1'b0;
    step();
    chk("t4_wc", 32'(word_count), 32'd1);

    // valid_in toggling: idle cycles must not shift acc
    for (int i = 0; i < 4; i++) begin
      send(2'b10);
      data_in  = 2'b01;
      valid_in = 1'b0;
      if (i < 3) step();
    end
    chk("t5_data", 32'(data_out), 32'hAA);
    chk("t5_valid", 32'(valid_out), 32'd1);
    step();
    chk("t5_wc", 32'(word_count), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
